axi_rd_beat_to_axis_buf: RTL and testbench

//  Downstream stage of the AXI DMA read master. Accepts AXI4 read-data beats
//  (R channel) from the master and buffers them in an internal FIFO.

---
 rtl/axi_rd_beat_to_axis_buf.sv | 149 ++++++++++++++
 tb/tb_axi_rd_beat_to_axis_buf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_beat_to_axis_buf.sv
// AXI4 R-channel beat buffer presenting stored beats as an AXI4-Stream master (FWFT FIFO).
// Optional AXIS_BUF_STATS_EN adds BEAT_CNT / PKT_CNT stream statistics counters.
module axi_rd_beat_to_axis_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  input  logic [1:0]              S_AXI_RRESP,
  input  logic                    S_AXI_RLAST,
  input  logic                    S_AXI_RVALID,
  output logic                    S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [CNT_W-1:0]        FIFO_LEVEL,
  output logic                    RD_ERROR,
  input  logic                    ERR_CLR
`ifdef AXIS_BUF_STATS_EN
  ,
  output logic [31:0]             BEAT_CNT,
  output logic [15:0]             PKT_CNT
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  // Each entry holds {RLAST, RDATA}; RRESP only feeds the sticky error flag.
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0] rd_word;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             err_q, err_d;

  logic full, empty;
  logic rready, tvalid;
  logic push, pop;
  logic unused_rresp;

  assign unused_rresp = S_AXI_RRESP[0];

  assign full  = (level_q == CNT_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);

  // Handshake outputs are forced low while reset is held, independent of stale state.
  assign rready = !full && !ARESET;
  assign tvalid = !empty && !ARESET;

  assign push = S_AXI_RVALID && rready;
  assign pop  = tvalid && M_AXIS_TREADY;

  assign rd_word = mem_q[rd_ptr_q];

  assign S_AXI_RREADY  = rready;
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = rd_word[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = tvalid && rd_word[DATA_WIDTH];
  assign M_AXIS_TKEEP  = '1;
  assign FIFO_LEVEL    = level_q;
  assign RD_ERROR      = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase

    // A new error in the same cycle as a clear keeps the flag set.
    if (ERR_CLR) begin
      err_d = 1'b0;
    end
    if (push && S_AXI_RRESP[1]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  // Storage array carries no reset; validity is tracked solely by the level counter.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {S_AXI_RLAST, S_AXI_RDATA};
    end
  end

`ifdef AXIS_BUF_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (ERR_CLR) begin
      beat_cnt_d = '0;
      pkt_cnt_d  = '0;
    end else if (pop) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (rd_word[DATA_WIDTH]) begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign BEAT_CNT = beat_cnt_q;
  assign PKT_CNT  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axi_rd_beat_to_axis_buf.sv
// Self-checking bench for axi_rd_beat_to_axis_buf: vector table, corner sequences, random run
// against a queue-based reference model.
module tb_axi_rd_beat_to_axis_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] tdata;
  logic [3:0]    tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [4:0]    level;
  logic          rd_error;
  logic          err_clr = 1'b0;
`ifdef AXIS_BUF_STATS_EN
  logic [31:0]   beat_cnt;
  logic [15:0]   pkt_cnt;
`endif

  always #5 clk = ~clk;

  axi_rd_beat_to_axis_buf #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK          (clk),
    .ARESET        (arst),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TKEEP  (tkeep),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .FIFO_LEVEL    (level),
    .RD_ERROR      (rd_error),
    .ERR_CLR       (err_clr)
`ifdef AXIS_BUF_STATS_EN
    ,
    .BEAT_CNT      (beat_cnt),
    .PKT_CNT       (pkt_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of {last, data} plus the sticky error flag.
  logic [DW:0] m_q[$];
  logic        m_err = 1'b0;
  logic [31:0] m_beats = '0;
  logic [15:0] m_pkts = '0;

  typedef struct {
    logic          a;
    logic          v;
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
    logic          t;
    logic          c;
    logic          e_rdy;
    logic          e_tv;
    logic [DW-1:0] e_td;
    logic          e_tl;
    logic [4:0]    e_lvl;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setin(input logic a, input logic v, input logic [DW-1:0] d, input logic [1:0] r,
                       input logic l, input logic t, input logic c);
    @(negedge clk);
    arst = a; rvalid = v; rdata = d; rresp = r; rlast = l; tready = t; err_clr = c;
    #1;
  endtask

  task automatic check_model();
    logic e_tv;
    e_tv = !arst && (m_q.size() > 0);
    chk("rready", rready, !arst && (m_q.size() < DEPTH));
    chk("tvalid", tvalid, e_tv);
    chk("level", level, m_q.size());
    chk("rd_error", rd_error, m_err);
    chk("tkeep", tkeep, 4'hf);
    if (e_tv) begin
      chk("tdata", tdata, m_q[0][DW-1:0]);
      chk("tlast", tlast, m_q[0][DW]);
    end else begin
      chk("tlast_idle", tlast, 1'b0);
    end
`ifdef AXIS_BUF_STATS_EN
    chk("beat_cnt", beat_cnt, m_beats);
    chk("pkt_cnt", pkt_cnt, m_pkts);
`endif
  endtask

  // Advance one clock and apply the same transfer rules to the model.
  task automatic tick();
    logic do_push, do_pop;
    logic [DW:0] head;
    do_push = !arst && rvalid && (m_q.size() < DEPTH);
    do_pop  = !arst && tready && (m_q.size() > 0);
    head    = (m_q.size() > 0) ? m_q[0] : '0;
    @(posedge clk);
    if (arst) begin
      m_q.delete();
      m_err = 1'b0;
      m_beats = '0;
      m_pkts = '0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({rlast, rdata});
      if (err_clr) m_err = 1'b0;
      if (do_push && rresp[1]) m_err = 1'b1;
      if (err_clr) begin
        m_beats = '0;
        m_pkts = '0;
      end else if (do_pop) begin
        m_beats = m_beats + 1;
        if (head[DW]) m_pkts = m_pkts + 1;
      end
    end
  endtask

  task automatic cyc(input logic a, input logic v, input logic [DW-1:0] d, input logic [1:0] r,
                     input logic l, input logic t, input logic c);
    setin(a, v, d, r, l, t, c);
    check_model();
    tick();
  endtask

  function automatic vec_t mk(input logic a, v, input logic [DW-1:0] d, input logic [1:0] r,
                              input logic l, t, c, e_rdy, e_tv, input logic [DW-1:0] e_td,
                              input logic e_tl, input logic [4:0] e_lvl, input logic e_err);
    vec_t x;
    x.a = a; x.v = v; x.d = d; x.r = r; x.l = l; x.t = t; x.c = c;
    x.e_rdy = e_rdy; x.e_tv = e_tv; x.e_td = e_td; x.e_tl = e_tl; x.e_lvl = e_lvl;
    x.e_err = e_err;
    return x;
  endfunction

  logic [DW-1:0] seq;

  initial begin
    // Expected values are the outputs seen before the edge that consumes the row's inputs.
    //            a  v  d      r     l  t  c  rdy tv td     tl lvl err
    vecs.push_back(mk(1, 1, 32'h99, 2'b10, 1, 1, 0, 0, 0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h00, 2'b00, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h11, 2'b00, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h22, 2'b10, 0, 0, 0, 1, 1, 32'h11, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h33, 2'b00, 1, 1, 0, 1, 1, 32'h11, 0, 2, 1));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 1, 1, 1, 1, 32'h22, 0, 2, 1));
    vecs.push_back(mk(0, 1, 32'h44, 2'b10, 0, 0, 1, 1, 1, 32'h33, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 1, 0, 1, 1, 32'h33, 1, 2, 1));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 1, 0, 1, 1, 32'h44, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 0, 0, 1, 0, 32'h0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 0, 1, 1, 0, 32'h0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h00, 2'b00, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0));

    // First reset edge brings the DUT out of its unknown power-up state.
    setin(1, 0, '0, 2'b00, 0, 0, 0);
    tick();

    foreach (vecs[i]) begin
      setin(vecs[i].a, vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].l, vecs[i].t, vecs[i].c);
      chk($sformatf("vec%0d_rready", i), rready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_tvalid", i), tvalid, vecs[i].e_tv);
      chk($sformatf("vec%0d_level", i), level, vecs[i].e_lvl);
      chk($sformatf("vec%0d_err", i), rd_error, vecs[i].e_err);
      if (vecs[i].e_tv) begin
        chk($sformatf("vec%0d_tdata", i), tdata, vecs[i].e_td);
        chk($sformatf("vec%0d_tlast", i), tlast, vecs[i].e_tl);
      end
      tick();
    end

    // Burst of 4 with TREADY high: each beat visible the cycle after its accept.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h11 * (i + 1), 2'b00, i == 3, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 2'b00, 0, 1, 0);

    // Fill to full with consumer stalled; 17th beat must be held off.
    seq = 32'h1000;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cyc(0, 1, seq, 2'b00, (i % 4) == 3, 0, 0);
      if (i < DEPTH) seq++;
    end
    setin(0, 1, seq, 2'b00, 0, 1, 0);
    chk("full_level", level, 5'd16);
    chk("full_rready", rready, 1'b0);
    check_model();
    tick();
    setin(0, 1, seq, 2'b00, 0, 0, 0);
    chk("after_pop_rready", rready, 1'b1);
    chk("after_pop_level", level, 5'd15);
    check_model();
    tick();
    seq++;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, seq, 2'b00, 0, 1, 0);
      seq++;
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, '0, 2'b00, 0, 1, 0);

    // Steady push+pop at level 5 across pointer wraps.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, seq, 2'b00, 0, 0, 0);
      seq++;
    end
    for (int i = 0; i < 40; i++) begin
      setin(0, 1, seq, 2'b00, (i % 8) == 7, 1, 0);
      chk("steady_level", level, 5'd5);
      check_model();
      tick();
      seq++;
    end
    for (int i = 0; i < 7; i++) cyc(0, 0, '0, 2'b00, 0, 1, 0);

    // Reset in the middle of a burst discards everything.
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, seq, 2'b00, 0, 0, 0);
      seq++;
    end
    setin(0, 0, '0, 2'b00, 0, 0, 0);
    chk("midburst_level", level, 5'd7);
    tick();
    cyc(1, 1, seq, 2'b10, 0, 1, 0);
    setin(0, 0, '0, 2'b00, 0, 1, 0);
    chk("post_reset_level", level, 5'd0);
    chk("post_reset_tvalid", tvalid, 1'b0);
    tick();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(0, 1, seq, 2'b00, i == 3, 1, 0);
        seq++;
      end
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 2'b00, 0, 1, 0);
`ifdef AXIS_BUF_STATS_EN
    setin(0, 0, '0, 2'b00, 0, 1, 0);
    chk("stats_beats", beat_cnt, 32'd8);
    chk("stats_pkts", pkt_cnt, 16'd2);
    tick();
`endif

    // Randomised traffic with phases of varying producer/consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      int pv, pt;
      pv = ((i / 250) % 3 == 0) ? 90 : 50;
      pt = ((i / 250) % 3 == 1) ? 20 : 70;
      cyc($urandom_range(0, 399) == 0,
          $urandom_range(0, 99) < pv,
          $urandom,
          ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < pt,
          $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
